mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester, one-port AXI4-Lite arbiter between the instruction-fetch unit (read-only) and the load/store unit (read and write).
- Drives the single memory/bus master port of the core.
- One outstanding transaction at a time; no added address-phase latency when the port is idle.
- Round-robin tie-break between IFU and LSU, so neither starves the other in the multi-cycle fetch/execute flow.

Parameters:
AW, 64, address width
DW, 64, data width (strobe width DW/8)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ifu_ARVALID/ARREADY  in/out  1/1  IFU read address handshake
ifu_ARADDR  in  AW  IFU read address
ifu_ARPROT  in  3  IFU protection bits
ifu_RVALID/RREADY  out/in  1/1  IFU read data handshake
ifu_RDATA  out  DW  IFU read data
ifu_RRESP  out  2  IFU read response
lsu_ARVALID/ARREADY, lsu_ARADDR, lsu_ARPROT  in/out/in/in  1/1/AW/3  LSU read address
lsu_RVALID/RREADY, lsu_RDATA, lsu_RRESP  out/in/out/out  1/1/DW/2  LSU read data
lsu_AWVALID/AWREADY, lsu_AWADDR, lsu_AWPROT  in/out/in/in  1/1/AW/3  LSU write address
lsu_WVALID/WREADY, lsu_WDATA, lsu_WSTRB  in/out/in/in  1/1/DW/DW/8  LSU write data
lsu_BVALID/BREADY, lsu_BRESP  out/in/out  1/1/2  LSU write response
mem_*  mirrored directions  same widths  full AXI4-Lite master port: AR, R, AW, W, B

Behaviour:
- Reset, synchronous, rstn=0:
  - state=IDLE, last_lsu=0, aw_done=0, w_done=0.
  - All mem_*VALID, mem_RREADY and mem_BREADY are 0.
  - All requester READY/VALID outputs are 0; RDATA and RRESP outputs are 0.
- States: IDLE, I_ADDR, L_RADDR, L_WADDR, I_RESP, L_RRESP, L_BRESP.
- IDLE winner selection (combinational):
  - LSU request = lsu_AWVALID | lsu_ARVALID. Within the LSU, write wins over read.
  - If the IFU and LSU both request: LSU wins when last_lsu=0, IFU wins when last_lsu=1.
  - The winner's AR (or AW+W) is forwarded to mem_* in the same cycle. The winner gets mem READY; the loser sees READY=0.
- Address phase:
  - If the handshake completes in IDLE, go directly to the matching RESP state.
  - Otherwise go to I_ADDR / L_RADDR / L_WADDR and hold that grant until the handshake. This keeps mem VALID/ADDR stable once asserted, as AXI requires.
  - last_lsu is updated on every grant commit: 1 for an LSU grant, 0 for an IFU grant.
- Write (L_WADDR):
  - AW and W are forwarded independently. aw_done and w_done are set on their respective handshakes.
  - A channel that is already done has its mem VALID masked to 0.
  - Go to L_BRESP in the cycle both handshakes are complete. This includes same-cycle completion and completion while still in IDLE.
  - aw_done and w_done are cleared on entering L_BRESP.
- Response phases:
  - I_RESP: mem R is routed to the IFU and mem_RREADY = ifu_RREADY.
  - L_RRESP: mem R is routed to the LSU and mem_RREADY = lsu_RREADY.
  - L_BRESP: mem B is routed to the LSU and mem_BREADY = lsu_BREADY.
  - On the response handshake, return to IDLE. A new grant is possible the cycle after.
  - A non-owner always sees VALID=0 and data/resp=0.
  - RRESP/BRESP are passed through unmodified (SLVERR/DECERR included).
- Boundaries:
  - A mem response arriving outside a RESP state is not acknowledged (READY=0).
  - A request arriving while busy waits; its READY stays 0.
  - Reset mid-transaction returns to IDLE and drops any in-flight response. The memory slave is reset on the same rstn.
  - A requester dropping VALID before its handshake is a protocol violation. The arbiter keeps the grant; behaviour is otherwise undefined.
- Throughput: one transaction per 2 cycles minimum (zero-wait slave).

Decomposition:
- Shared package arb_pkg:
  - state enum encoding (3 bits);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - PROT_IFU=3'b100, PROT_LSU=3'b000.
- One sub-module: rr_pick2, a 2-way round-robin picker. Inputs req[1:0] and last; outputs a one-hot grant. Combinational only; last is held in the parent.

Test Plan:
- Solo IFU fetch, addr 0x8000_0000, slave ARREADY=1 in cycle 0 and RVALID in cycle 2 with data 0x00100073 -> IFU sees ARREADY in cycle 0 and RVALID/RDATA=0x00100073 in cycle 2; state IDLE in cycle 3.
- IFU and LSU read requested in the same cycle after reset -> LSU granted first (last_lsu=0). IFU ARREADY=0 until the LSU R handshake. IFU is granted on the next IDLE cycle.
- Back-to-back contention for 4 transactions -> grant order LSU, IFU, LSU, IFU.
- LSU write where slave accepts W in cycle 1 and AW in cycle 3 -> mem_WVALID drops after cycle 1, state enters L_BRESP in cycle 4; BRESP=2'b10 is delivered unmodified to the LSU.
- Slave holds ARREADY=0 for 3 cycles while the IFU requests mid-stall -> mem_ARADDR and mem_ARVALID stay constant; IFU ARREADY=0; the grant is not switched.
- rstn=0 asserted in L_RRESP with the slave's RVALID pending -> next cycle state=IDLE, all VALID/READY outputs 0, lsu_RVALID never asserted.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared encodings for the IFU/LSU memory port arbiter
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_ADDR  = 3'd1,
        L_RADDR = 3'd2,
        L_WADDR = 3'd3,
        I_RESP  = 3'd4,
        L_RRESP = 3'd5,
        L_BRESP = 3'd6
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_IFU = 3'b100;
    localparam logic [2:0] PROT_LSU = 3'b000;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker, req[1] wins a tie unless it won last
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding AXI4-Lite arbiter, IFU reads vs LSU reads/writes
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              ifu_ARVALID,
    output logic              ifu_ARREADY,
    input  logic [AW-1:0]     ifu_ARADDR,
    input  logic [2:0]        ifu_ARPROT,
    output logic              ifu_RVALID,
    input  logic              ifu_RREADY,
    output logic [DW-1:0]     ifu_RDATA,
    output logic [1:0]        ifu_RRESP,

    input  logic              lsu_ARVALID,
    output logic              lsu_ARREADY,
    input  logic [AW-1:0]     lsu_ARADDR,
    input  logic [2:0]        lsu_ARPROT,
    output logic              lsu_RVALID,
    input  logic              lsu_RREADY,
    output logic [DW-1:0]     lsu_RDATA,
    output logic [1:0]        lsu_RRESP,
    input  logic              lsu_AWVALID,
    output logic              lsu_AWREADY,
    input  logic [AW-1:0]     lsu_AWADDR,
    input  logic [2:0]        lsu_AWPROT,
    input  logic              lsu_WVALID,
    output logic              lsu_WREADY,
    input  logic [DW-1:0]     lsu_WDATA,
    input  logic [DW/8-1:0]   lsu_WSTRB,
    output logic              lsu_BVALID,
    input  logic              lsu_BREADY,
    output logic [1:0]        lsu_BRESP,

    output logic              mem_ARVALID,
    input  logic              mem_ARREADY,
    output logic [AW-1:0]     mem_ARADDR,
    output logic [2:0]        mem_ARPROT,
    input  logic              mem_RVALID,
    output logic              mem_RREADY,
    input  logic [DW-1:0]     mem_RDATA,
    input  logic [1:0]        mem_RRESP,
    output logic              mem_AWVALID,
    input  logic              mem_AWREADY,
    output logic [AW-1:0]     mem_AWADDR,
    output logic [2:0]        mem_AWPROT,
    output logic              mem_WVALID,
    input  logic              mem_WREADY,
    output logic [DW-1:0]     mem_WDATA,
    output logic [DW/8-1:0]   mem_WSTRB,
    input  logic              mem_BVALID,
    output logic              mem_BREADY,
    input  logic [1:0]        mem_BRESP
);

    arb_state_e state;
    logic       last_lsu;
    logic       aw_done;
    logic       w_done;

    logic [1:0] req;
    logic [1:0] grant;
    logic       route_ifu_ar, route_lsu_ar, route_lsu_w;
    logic       route_ifu_r, route_lsu_r, route_lsu_b;
    logic       ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic       aw_all, w_all;

    assign req = {lsu_AWVALID | lsu_ARVALID, ifu_ARVALID};

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_lsu),
        .grant (grant)
    );

    // Every route is gated by rstn so nothing leaks to either side while reset is held.
    always_comb begin
        route_ifu_ar = 1'b0;
        route_lsu_ar = 1'b0;
        route_lsu_w  = 1'b0;
        if (rstn) begin
            case (state)
                IDLE: begin
                    route_ifu_ar = grant[0];
                    route_lsu_w  = grant[1] & lsu_AWVALID;
                    route_lsu_ar = grant[1] & ~lsu_AWVALID;
                end
                I_ADDR:  route_ifu_ar = 1'b1;
                L_RADDR: route_lsu_ar = 1'b1;
                L_WADDR: route_lsu_w  = 1'b1;
                default: ;
            endcase
        end
    end

    assign route_ifu_r = rstn && (state == I_RESP);
    assign route_lsu_r = rstn && (state == L_RRESP);
    assign route_lsu_b = rstn && (state == L_BRESP);

    assign mem_ARVALID = (route_ifu_ar & ifu_ARVALID) | (route_lsu_ar & lsu_ARVALID);
    assign mem_ARADDR  = route_ifu_ar ? ifu_ARADDR : (route_lsu_ar ? lsu_ARADDR : '0);
    assign mem_ARPROT  = route_ifu_ar ? ifu_ARPROT : (route_lsu_ar ? lsu_ARPROT : 3'b000);
    assign ifu_ARREADY = route_ifu_ar & mem_ARREADY;
    assign lsu_ARREADY = route_lsu_ar & mem_ARREADY;

    // A write channel that already handshook is masked so the slave never sees a second beat.
    assign mem_AWVALID = route_lsu_w & lsu_AWVALID & ~aw_done;
    assign mem_AWADDR  = route_lsu_w ? lsu_AWADDR : '0;
    assign mem_AWPROT  = route_lsu_w ? lsu_AWPROT : 3'b000;
    assign lsu_AWREADY = route_lsu_w & ~aw_done & mem_AWREADY;
    assign mem_WVALID  = route_lsu_w & lsu_WVALID & ~w_done;
    assign mem_WDATA   = route_lsu_w ? lsu_WDATA : '0;
    assign mem_WSTRB   = route_lsu_w ? lsu_WSTRB : '0;
    assign lsu_WREADY  = route_lsu_w & ~w_done & mem_WREADY;

    assign ifu_RVALID = route_ifu_r & mem_RVALID;
    assign ifu_RDATA  = route_ifu_r ? mem_RDATA : '0;
    assign ifu_RRESP  = route_ifu_r ? mem_RRESP : 2'b00;
    assign lsu_RVALID = route_lsu_r & mem_RVALID;
    assign lsu_RDATA  = route_lsu_r ? mem_RDATA : '0;
    assign lsu_RRESP  = route_lsu_r ? mem_RRESP : 2'b00;
    assign mem_RREADY = (route_ifu_r & ifu_RREADY) | (route_lsu_r & lsu_RREADY);

    assign lsu_BVALID = route_lsu_b & mem_BVALID;
    assign lsu_BRESP  = route_lsu_b ? mem_BRESP : 2'b00;
    assign mem_BREADY = route_lsu_b & lsu_BREADY;

    assign ar_hs  = mem_ARVALID & mem_ARREADY;
    assign aw_hs  = mem_AWVALID & mem_AWREADY;
    assign w_hs   = mem_WVALID & mem_WREADY;
    assign r_hs   = mem_RVALID & mem_RREADY;
    assign b_hs   = mem_BVALID & mem_BREADY;
    assign aw_all = aw_done | aw_hs;
    assign w_all  = w_done | w_hs;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            last_lsu <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (route_ifu_ar) begin
                        last_lsu <= 1'b0;
                        state    <= ar_hs ? I_RESP : I_ADDR;
                    end else if (route_lsu_ar) begin
                        last_lsu <= 1'b1;
                        state    <= ar_hs ? L_RRESP : L_RADDR;
                    end else if (route_lsu_w) begin
                        last_lsu <= 1'b1;
                        if (aw_all && w_all) begin
                            state <= L_BRESP;
                        end else begin
                            state   <= L_WADDR;
                            aw_done <= aw_hs;
                            w_done  <= w_hs;
                        end
                    end
                end
                I_ADDR:  if (ar_hs) state <= I_RESP;
                L_RADDR: if (ar_hs) state <= L_RRESP;
                L_WADDR: begin
                    if (aw_all && w_all) begin
                        state   <= L_BRESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_all;
                        w_done  <= w_all;
                    end
                end
                I_RESP:  if (r_hs) state <= IDLE;
                L_RRESP: if (r_hs) state <= IDLE;
                L_BRESP: if (b_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rstn;

    logic ifu_ARVALID, ifu_ARREADY, ifu_RVALID, ifu_RREADY;
    logic [AW-1:0] ifu_ARADDR;
    logic [2:0] ifu_ARPROT;
    logic [DW-1:0] ifu_RDATA;
    logic [1:0] ifu_RRESP;
    logic lsu_ARVALID, lsu_ARREADY, lsu_RVALID, lsu_RREADY;
    logic [AW-1:0] lsu_ARADDR;
    logic [2:0] lsu_ARPROT;
    logic [DW-1:0] lsu_RDATA;
    logic [1:0] lsu_RRESP;
    logic lsu_AWVALID, lsu_AWREADY, lsu_WVALID, lsu_WREADY, lsu_BVALID, lsu_BREADY;
    logic [AW-1:0] lsu_AWADDR;
    logic [2:0] lsu_AWPROT;
    logic [DW-1:0] lsu_WDATA;
    logic [DW/8-1:0] lsu_WSTRB;
    logic [1:0] lsu_BRESP;
    logic mem_ARVALID, mem_ARREADY, mem_RVALID, mem_RREADY;
    logic [AW-1:0] mem_ARADDR;
    logic [2:0] mem_ARPROT;
    logic [DW-1:0] mem_RDATA;
    logic [1:0] mem_RRESP;
    logic mem_AWVALID, mem_AWREADY, mem_WVALID, mem_WREADY, mem_BVALID, mem_BREADY;
    logic [AW-1:0] mem_AWADDR;
    logic [2:0] mem_AWPROT;
    logic [DW-1:0] mem_WDATA;
    logic [DW/8-1:0] mem_WSTRB;
    logic [1:0] mem_BRESP;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] A_IFU  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A_IFU2 = 64'h0000_0000_8000_0004;
    localparam logic [63:0] A_LSU  = 64'h0000_0000_1000_0000;
    localparam logic [63:0] A_LSU2 = 64'h0000_0000_3000_0008;
    localparam logic [63:0] A_WR   = 64'h0000_0000_2000_0040;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_ARVALID(ifu_ARVALID), .ifu_ARREADY(ifu_ARREADY), .ifu_ARADDR(ifu_ARADDR),
        .ifu_ARPROT(ifu_ARPROT), .ifu_RVALID(ifu_RVALID), .ifu_RREADY(ifu_RREADY),
        .ifu_RDATA(ifu_RDATA), .ifu_RRESP(ifu_RRESP),
        .lsu_ARVALID(lsu_ARVALID), .lsu_ARREADY(lsu_ARREADY), .lsu_ARADDR(lsu_ARADDR),
        .lsu_ARPROT(lsu_ARPROT), .lsu_RVALID(lsu_RVALID), .lsu_RREADY(lsu_RREADY),
        .lsu_RDATA(lsu_RDATA), .lsu_RRESP(lsu_RRESP),
        .lsu_AWVALID(lsu_AWVALID), .lsu_AWREADY(lsu_AWREADY), .lsu_AWADDR(lsu_AWADDR),
        .lsu_AWPROT(lsu_AWPROT), .lsu_WVALID(lsu_WVALID), .lsu_WREADY(lsu_WREADY),
        .lsu_WDATA(lsu_WDATA), .lsu_WSTRB(lsu_WSTRB), .lsu_BVALID(lsu_BVALID),
        .lsu_BREADY(lsu_BREADY), .lsu_BRESP(lsu_BRESP),
        .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY), .mem_ARADDR(mem_ARADDR),
        .mem_ARPROT(mem_ARPROT), .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY),
        .mem_RDATA(mem_RDATA), .mem_RRESP(mem_RRESP),
        .mem_AWVALID(mem_AWVALID), .mem_AWREADY(mem_AWREADY), .mem_AWADDR(mem_AWADDR),
        .mem_AWPROT(mem_AWPROT), .mem_WVALID(mem_WVALID), .mem_WREADY(mem_WREADY),
        .mem_WDATA(mem_WDATA), .mem_WSTRB(mem_WSTRB), .mem_BVALID(mem_BVALID),
        .mem_BREADY(mem_BREADY), .mem_BRESP(mem_BRESP)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_ARVALID = 1'b0; ifu_ARADDR = '0; ifu_ARPROT = 3'b000; ifu_RREADY = 1'b0;
        lsu_ARVALID = 1'b0; lsu_ARADDR = '0; lsu_ARPROT = 3'b000; lsu_RREADY = 1'b0;
        lsu_AWVALID = 1'b0; lsu_AWADDR = '0; lsu_AWPROT = 3'b000;
        lsu_WVALID = 1'b0; lsu_WDATA = '0; lsu_WSTRB = '0; lsu_BREADY = 1'b0;
        mem_ARREADY = 1'b0; mem_RVALID = 1'b0; mem_RDATA = '0; mem_RRESP = 2'b00;
        mem_AWREADY = 1'b0; mem_WREADY = 1'b0; mem_BVALID = 1'b0; mem_BRESP = 2'b00;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        // Reset with requests and responses pending: all outputs must stay quiet.
        rstn = 1'b0;
        clear_inputs();
        ifu_ARVALID = 1'b1; lsu_AWVALID = 1'b1; lsu_WVALID = 1'b1;
        mem_RVALID = 1'b1; mem_BVALID = 1'b1; mem_RDATA = 64'h55;
        ifu_RREADY = 1'b1; lsu_BREADY = 1'b1;
        cyc(); cyc(); smp();
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_mem_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("rst_mem_awvalid", 64'(mem_AWVALID), 64'd0);
        chk("rst_mem_wvalid", 64'(mem_WVALID), 64'd0);
        chk("rst_mem_rready", 64'(mem_RREADY), 64'd0);
        chk("rst_mem_bready", 64'(mem_BREADY), 64'd0);
        chk("rst_ifu_arready", 64'(ifu_ARREADY), 64'd0);
        chk("rst_ifu_rvalid", 64'(ifu_RVALID), 64'd0);
        chk("rst_ifu_rdata", ifu_RDATA, 64'd0);
        chk("rst_lsu_bvalid", 64'(lsu_BVALID), 64'd0);
        cyc();
        clear_inputs();
        rstn = 1'b1;

        // Solo IFU fetch, zero-wait address, data in cycle 2.
        ifu_ARVALID = 1'b1; ifu_ARADDR = A_IFU; ifu_ARPROT = PROT_IFU; mem_ARREADY = 1'b1;
        smp();
        chk("solo_arvalid", 64'(mem_ARVALID), 64'd1);
        chk("solo_araddr", mem_ARADDR, A_IFU);
        chk("solo_arprot", 64'(mem_ARPROT), 64'd4);
        chk("solo_ifu_arready", 64'(ifu_ARREADY), 64'd1);
        chk("solo_lsu_arready", 64'(lsu_ARREADY), 64'd0);
        cyc();
        ifu_ARVALID = 1'b0; mem_ARREADY = 1'b0; ifu_RREADY = 1'b1;
        smp();
        chk("solo_state_c1", 64'(dut.state), 64'(I_RESP));
        chk("solo_rvalid_c1", 64'(ifu_RVALID), 64'd0);
        cyc();
        mem_RVALID = 1'b1; mem_RDATA = 64'h0000_0000_0010_0073; mem_RRESP = RESP_OKAY;
        smp();
        chk("solo_rvalid_c2", 64'(ifu_RVALID), 64'd1);
        chk("solo_rdata_c2", ifu_RDATA, 64'h0000_0000_0010_0073);
        chk("solo_mem_rready", 64'(mem_RREADY), 64'd1);
        chk("solo_lsu_rvalid", 64'(lsu_RVALID), 64'd0);
        cyc();
        mem_RVALID = 1'b0; mem_RDATA = '0;
        smp();
        chk("solo_state_c3", 64'(dut.state), 64'(IDLE));

        // Simultaneous IFU/LSU read after reset: LSU first, IFU waits.
        do_reset();
        ifu_ARVALID = 1'b1; ifu_ARADDR = A_IFU2; ifu_ARPROT = PROT_IFU;
        lsu_ARVALID = 1'b1; lsu_ARADDR = A_LSU; lsu_ARPROT = PROT_LSU; mem_ARREADY = 1'b1;
        smp();
        chk("tie_araddr", mem_ARADDR, A_LSU);
        chk("tie_lsu_arready", 64'(lsu_ARREADY), 64'd1);
        chk("tie_ifu_arready", 64'(ifu_ARREADY), 64'd0);
        cyc();
        lsu_ARVALID = 1'b0;
        smp();
        chk("tie_state", 64'(dut.state), 64'(L_RRESP));
        chk("tie_busy_ifu_arready", 64'(ifu_ARREADY), 64'd0);
        chk("tie_busy_arvalid", 64'(mem_ARVALID), 64'd0);
        cyc();
        mem_RVALID = 1'b1; mem_RDATA = 64'hDEAD_BEEF_0000_0001; mem_RRESP = RESP_SLVERR;
        lsu_RREADY = 1'b1;
        smp();
        chk("tie_lsu_rvalid", 64'(lsu_RVALID), 64'd1);
        chk("tie_lsu_rdata", lsu_RDATA, 64'hDEAD_BEEF_0000_0001);
        chk("tie_lsu_rresp", 64'(lsu_RRESP), 64'(RESP_SLVERR));
        chk("tie_ifu_rvalid", 64'(ifu_RVALID), 64'd0);
        chk("tie_ifu_rdata", ifu_RDATA, 64'd0);
        chk("tie_ifu_arready_r", 64'(ifu_ARREADY), 64'd0);
        cyc();
        mem_RVALID = 1'b0; lsu_RREADY = 1'b0;
        smp();
        chk("tie_state_idle", 64'(dut.state), 64'(IDLE));
        chk("tie_ifu_araddr", mem_ARADDR, A_IFU2);
        chk("tie_ifu_granted", 64'(ifu_ARREADY), 64'd1);
        cyc();
        ifu_ARVALID = 1'b0; mem_ARREADY = 1'b0; ifu_RREADY = 1'b1; mem_RVALID = 1'b1;
        smp();
        chk("tie_ifu_rvalid2", 64'(ifu_RVALID), 64'd1);
        cyc();
        clear_inputs();

        // Back-to-back contention with a zero-wait slave: LSU, IFU, LSU, IFU.
        ifu_ARVALID = 1'b1; ifu_ARADDR = A_IFU; lsu_ARVALID = 1'b1; lsu_ARADDR = A_LSU;
        mem_ARREADY = 1'b1; mem_RVALID = 1'b1; ifu_RREADY = 1'b1; lsu_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("rr_araddr", mem_ARADDR, (i % 2 == 0) ? A_LSU : A_IFU);
            chk("rr_idle_rready", 64'(mem_RREADY), 64'd0);
            cyc();
            smp();
            chk("rr_lsu_owner", 64'(lsu_RVALID), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_ifu_owner", 64'(ifu_RVALID), (i % 2 == 0) ? 64'd0 : 64'd1);
            cyc();
        end
        clear_inputs();

        // LSU write: W accepted in cycle 1, AW in cycle 3, SLVERR response.
        lsu_AWVALID = 1'b1; lsu_AWADDR = A_WR; lsu_AWPROT = PROT_LSU;
        lsu_WVALID = 1'b1; lsu_WDATA = 64'h0123_4567_89AB_CDEF; lsu_WSTRB = 8'h0F;
        smp();
        chk("wr_awvalid", 64'(mem_AWVALID), 64'd1);
        chk("wr_awaddr", mem_AWADDR, A_WR);
        chk("wr_wvalid_c0", 64'(mem_WVALID), 64'd1);
        chk("wr_wdata", mem_WDATA, 64'h0123_4567_89AB_CDEF);
        chk("wr_wstrb", 64'(mem_WSTRB), 64'h0F);
        chk("wr_awready_c0", 64'(lsu_AWREADY), 64'd0);
        cyc();
        mem_WREADY = 1'b1;
        smp();
        chk("wr_state_c1", 64'(dut.state), 64'(L_WADDR));
        chk("wr_wready_c1", 64'(lsu_WREADY), 64'd1);
        cyc();
        smp();
        chk("wr_wvalid_masked", 64'(mem_WVALID), 64'd0);
        chk("wr_wready_masked", 64'(lsu_WREADY), 64'd0);
        chk("wr_awvalid_c2", 64'(mem_AWVALID), 64'd1);
        cyc();
        mem_AWREADY = 1'b1;
        smp();
        chk("wr_awready_c3", 64'(lsu_AWREADY), 64'd1);
        chk("wr_state_c3", 64'(dut.state), 64'(L_WADDR));
        cyc();
        clear_inputs();
        mem_BVALID = 1'b1; mem_BRESP = RESP_SLVERR; lsu_BREADY = 1'b1;
        smp();
        chk("wr_state_c4", 64'(dut.state), 64'(L_BRESP));
        chk("wr_bvalid", 64'(lsu_BVALID), 64'd1);
        chk("wr_bresp", 64'(lsu_BRESP), 64'(RESP_SLVERR));
        chk("wr_bready", 64'(mem_BREADY), 64'd1);
        cyc();
        clear_inputs();
        smp();
        chk("wr_state_c5", 64'(dut.state), 64'(IDLE));

        // Write with both channels accepted while still idle, DECERR response.
        cyc();
        lsu_AWVALID = 1'b1; lsu_AWADDR = A_WR; lsu_WVALID = 1'b1; lsu_WDATA = 64'h77;
        lsu_WSTRB = 8'hFF; mem_AWREADY = 1'b1; mem_WREADY = 1'b1;
        smp();
        chk("wr0_awready", 64'(lsu_AWREADY), 64'd1);
        chk("wr0_wready", 64'(lsu_WREADY), 64'd1);
        cyc();
        clear_inputs();
        mem_BVALID = 1'b1; mem_BRESP = RESP_DECERR; lsu_BREADY = 1'b1;
        smp();
        chk("wr0_state", 64'(dut.state), 64'(L_BRESP));
        chk("wr0_bresp", 64'(lsu_BRESP), 64'(RESP_DECERR));
        cyc();
        clear_inputs();

        // LSU read stalled three cycles; IFU arrives mid-stall and must not steal the grant.
        lsu_ARVALID = 1'b1; lsu_ARADDR = A_LSU2; lsu_ARPROT = PROT_LSU;
        smp();
        chk("stall_arvalid_c0", 64'(mem_ARVALID), 64'd1);
        chk("stall_araddr_c0", mem_ARADDR, A_LSU2);
        cyc();
        ifu_ARVALID = 1'b1; ifu_ARADDR = A_IFU;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("stall_state", 64'(dut.state), 64'(L_RADDR));
            chk("stall_arvalid", 64'(mem_ARVALID), 64'd1);
            chk("stall_araddr", mem_ARADDR, A_LSU2);
            chk("stall_ifu_arready", 64'(ifu_ARREADY), 64'd0);
            cyc();
        end
        mem_ARREADY = 1'b1;
        smp();
        chk("stall_lsu_arready", 64'(lsu_ARREADY), 64'd1);
        chk("stall_ifu_arready3", 64'(ifu_ARREADY), 64'd0);
        cyc();
        lsu_ARVALID = 1'b0; mem_ARREADY = 1'b0;
        smp();
        chk("stall_state_resp", 64'(dut.state), 64'(L_RRESP));

        // Reset in L_RRESP with a response pending: it must be dropped.
        cyc();
        rstn = 1'b0; mem_RVALID = 1'b1; mem_RDATA = 64'hBAD; lsu_RREADY = 1'b1;
        smp();
        chk("mid_rst_lsu_rvalid", 64'(lsu_RVALID), 64'd0);
        chk("mid_rst_rready", 64'(mem_RREADY), 64'd0);
        cyc();
        clear_inputs();
        rstn = 1'b1;
        smp();
        chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
        chk("mid_rst_lsu_rvalid2", 64'(lsu_RVALID), 64'd0);
        chk("mid_rst_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("mid_rst_rready2", 64'(mem_RREADY), 64'd0);

        // last_lsu was 1 before the reset; a tie now must again go to the LSU.
        cyc();
        ifu_ARVALID = 1'b1; ifu_ARADDR = A_IFU; lsu_ARVALID = 1'b1; lsu_ARADDR = A_LSU;
        smp();
        chk("post_rst_tie_addr", mem_ARADDR, A_LSU);
        cyc();
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
